// File: rtl/axi_stripe_pkg.sv
// Shared types and constants for the striped-subordinate arbiter slice.
package axi_stripe_pkg;

  typedef enum logic {
    GRANT_IDLE = 1'b0,
    GRANT_HELD = 1'b1
  } grant_state_e;

  localparam logic [1:0] CHANNEL_IDLE = 2'b00;
  localparam int unsigned STATS_CNT_W = 16;

endpackage

// File: rtl/axi_stripe_rr_pick.sv
// Combinational rotate-priority picker: first valid index at or above ptr, wrapping mod NUM_M.
module axi_stripe_rr_pick #(
  parameter int unsigned NUM_M = 2
) (
  input  logic [NUM_M-1:0]         valid,
  input  logic [$clog2(NUM_M)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(NUM_M)-1:0] id
);

  localparam int unsigned M_BITS = $clog2(NUM_M);

  always_comb begin
    found = 1'b0;
    id    = '0;
    for (int unsigned off = 0; off < NUM_M; off++) begin
      if (!found && valid[(32'(ptr) + off) % NUM_M]) begin
        found = 1'b1;
        id    = M_BITS'((32'(ptr) + off) % NUM_M);
      end
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; depth 2**ADDR_SIZE, active-low sync reset.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_SIZE  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_SIZE:0]    wr_ptr;
  logic [ADDR_SIZE:0]    rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  // Extra pointer bit separates the wrapped-full case from empty.
  assign full    = (wr_ptr[ADDR_SIZE] != rd_ptr[ADDR_SIZE]) &&
                   (wr_ptr[ADDR_SIZE-1:0] == rd_ptr[ADDR_SIZE-1:0]);
  assign rd_data = mem[rd_ptr[ADDR_SIZE-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[ADDR_SIZE-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axi_stripe_arbiter.sv
// Round-robin arbiter sharing the stripe router among NUM_M managers, with in-order response owner tracking.
// Optional AXI_STRIPE_ARB_STATS_EN adds per-manager saturating accept counters on grant_cnt.
module axi_stripe_arbiter
  import axi_stripe_pkg::*;
#(
  parameter int unsigned NUM_M          = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 20,
  parameter int unsigned OUTSTANDING    = 4
) (
  input  logic                            axi_clk,
  input  logic                            axi_resetn,
  input  logic [NUM_M-1:0]                mgr_avalid,
  input  logic [NUM_M*AXI_ADDR_WIDTH-1:0] mgr_addr,
  output logic [NUM_M-1:0]                mgr_accepted,
  output logic                            sub_avalid,
  output logic [AXI_ADDR_WIDTH-1:0]       sub_addr,
  input  logic                            req_accepted,
  input  logic                            resp_accepted,
  output logic                            resp_valid,
  output logic [$clog2(NUM_M)-1:0]        resp_mgr,
  output logic                            full
`ifdef AXI_STRIPE_ARB_STATS_EN
  ,
  output logic [NUM_M*STATS_CNT_W-1:0]    grant_cnt
`endif
);

  localparam int unsigned M_BITS = $clog2(NUM_M);
  localparam int unsigned A_SIZE = $clog2(OUTSTANDING);
  localparam int unsigned CNT_W  = A_SIZE + 1;

  grant_state_e               state_q, state_d;
  logic [M_BITS-1:0]          grant_id_q, grant_id_d;
  logic [M_BITS-1:0]          rr_ptr_q, rr_ptr_d;
  logic [AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]           outstanding_q, outstanding_d;
  logic [AXI_ADDR_WIDTH-1:0]  mgr_addr_arr [NUM_M];
  logic [M_BITS-1:0]          pick_ptr;
  logic [M_BITS-1:0]          pick_id;
  logic                       pick_found;
  logic                       accept_now;
  logic                       resp_now;
  logic                       cap_ok;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       fifo_push;

  always_comb begin
    for (int unsigned i = 0; i < NUM_M; i++) begin
      mgr_addr_arr[i] = mgr_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    end
  end

  assign sub_avalid = (state_q == GRANT_HELD);
  assign sub_addr   = addr_q;
  assign accept_now = req_accepted && sub_avalid;
  assign resp_valid = !fifo_empty;
  assign resp_now   = resp_accepted && resp_valid;
  assign full       = (outstanding_q == CNT_W'(OUTSTANDING));
  assign fifo_push  = accept_now && !fifo_full;

  // Re-grant in the accept cycle scans from the post-accept pointer so back-to-back grants rotate.
  always_comb begin
    pick_ptr = rr_ptr_q;
    if (accept_now) begin
      pick_ptr = (grant_id_q == M_BITS'(NUM_M - 1)) ? '0 : grant_id_q + M_BITS'(1);
    end
  end

  assign cap_ok = (32'(outstanding_q) + 32'(accept_now) - 32'(resp_now)) < OUTSTANDING;

  axi_stripe_rr_pick #(
    .NUM_M (NUM_M)
  ) u_pick (
    .valid (mgr_avalid),
    .ptr   (pick_ptr),
    .found (pick_found),
    .id    (pick_id)
  );

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    addr_d        = addr_q;
    rr_ptr_d      = pick_ptr;
    outstanding_d = outstanding_q + CNT_W'(accept_now) - CNT_W'(resp_now);
    mgr_accepted  = '0;
    if (accept_now) mgr_accepted[grant_id_q] = 1'b1;

    if (state_q == GRANT_HELD && !accept_now) begin
      state_d = GRANT_HELD;
    end else if (pick_found && cap_ok) begin
      state_d    = GRANT_HELD;
      grant_id_d = pick_id;
      addr_d     = mgr_addr_arr[pick_id];
    end else begin
      state_d = GRANT_IDLE;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      state_q       <= GRANT_IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      addr_q        <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      addr_q        <= addr_d;
      outstanding_q <= outstanding_d;
    end
  end

  sync_fifo #(
    .DATA_WIDTH (M_BITS),
    .ADDR_SIZE  (A_SIZE)
  ) u_id_fifo (
    .clk     (axi_clk),
    .rst_n   (axi_resetn),
    .wr_en   (fifo_push),
    .wr_data (grant_id_q),
    .rd_en   (resp_now),
    .rd_data (resp_mgr),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

`ifdef AXI_STRIPE_ARB_STATS_EN
  logic [STATS_CNT_W-1:0] cnt_q [NUM_M];

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      for (int unsigned i = 0; i < NUM_M; i++) cnt_q[i] <= '0;
    end else if (accept_now && cnt_q[grant_id_q] != '1) begin
      cnt_q[grant_id_q] <= cnt_q[grant_id_q] + 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_M; i++) begin
      grant_cnt[i*STATS_CNT_W +: STATS_CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule
